fetch_stage: RTL and testbench

Instruction-fetch stage that produces the fInstruction/fPC pair consumed by the fetch/decode pipeline latch. It honours that latch's Stall.
- Owns the PC register.
- Runs a req/ready handshake to instruction memory.
- Holds one fetched word in a skid buffer while decode is stalled.
- Inserts NOP bubbles (32'h00000000, identical to the latch reset value) on memory wait and branch redirect.

---
 rtl/fetch_stage.sv | 83 ++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// keeps one fetched word in a skid buffer while decode is stalled.
module fetch_stage #(
  parameter logic [9:0]  RESET_PC = 10'd0,
  parameter logic [31:0] NOP      = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [9:0]  BranchTarget,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] fInstruction,
  output logic [9:0]  fPC,
  output logic        dbg_held
);

  typedef enum logic {RUN, HELD} state_t;

  state_t      state;
  logic [9:0]  pc;
  logic [31:0] buf_instr;
  logic [9:0]  buf_pc;

  // Handshake: a word transfers from memory when imem_req && imem_ready in the
  // same cycle; it reaches the latch on an edge where Stall is low, otherwise it
  // is parked in the skid buffer and the request is withdrawn until delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= RUN;
      buf_instr <= NOP;
      buf_pc    <= RESET_PC;
    end else if (BranchTaken) begin
      pc        <= BranchTarget;
      state     <= RUN;
      buf_instr <= NOP;
      buf_pc    <= BranchTarget;
    end else begin
      case (state)
        RUN: begin
          if (imem_ready) begin
            pc <= pc + 10'd1;
            if (Stall) begin
              buf_instr <= imem_rdata;
              buf_pc    <= pc;
              state     <= HELD;
            end
          end
        end
        HELD: begin
          if (!Stall) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign imem_addr = pc;
  assign dbg_held  = (state == HELD);

  // Fetch outputs depend only on state, branch and memory; Stall only acts at the edge.
  always_comb begin
    imem_req     = 1'b0;
    fInstruction = NOP;
    fPC          = pc;
    if (rst) begin
      fPC = RESET_PC;
    end else if (BranchTaken) begin
      fPC = pc;
    end else if (state == HELD) begin
      fInstruction = buf_instr;
      fPC          = buf_pc;
    end else begin
      imem_req = 1'b1;
      if (imem_ready) fInstruction = imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (reset PC 0 and 3FE) driven in lockstep,
// checked each cycle against a rule-level model plus an in-order delivery queue.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br;
  logic [9:0]  tgt;
  logic        ready;

  logic        req_a, req_b, held_a, held_b;
  logic [9:0]  addr_a, addr_b, fpc_a, fpc_b;
  logic [31:0] rdata_a, rdata_b, ins_a, ins_b;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic       sb_on;

  // Reference model state, one slot per instance.
  logic [9:0]  m_pc[2];
  logic        m_held[2];
  logic [31:0] m_bi[2];
  logic [9:0]  m_bp[2];

  fetch_stage #(.RESET_PC(10'h000)) dut_a (
    .clk(clk), .rst(rst), .Stall(stall), .BranchTaken(br), .BranchTarget(tgt),
    .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a), .imem_ready(ready),
    .fInstruction(ins_a), .fPC(fpc_a), .dbg_held(held_a)
  );

  fetch_stage #(.RESET_PC(10'h3FE)) dut_b (
    .clk(clk), .rst(rst), .Stall(stall), .BranchTaken(br), .BranchTarget(tgt),
    .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b), .imem_ready(ready),
    .fInstruction(ins_b), .fPC(fpc_b), .dbg_held(held_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [9:0] a);
    return 32'hA000_0000 + {22'd0, a};
  endfunction

  // Memory returns garbage when not ready so a DUT that ignores imem_ready shows it.
  assign rdata_a = ready ? mem(addr_a) : 32'hDEAD_BEEF;
  assign rdata_b = ready ? mem(addr_b) : 32'hDEAD_BEEF;

  function automatic logic [9:0] rpc(input int k);
    return (k == 0) ? 10'h000 : 10'h3FE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]   = rpc(k);
      m_held[k] = 1'b0;
      m_bi[k]   = 32'h0;
      m_bp[k]   = rpc(k);
    end
  endtask

  // One clock: drive at negedge, check 1ns later (before the rising edge), advance model.
  task automatic cycle(input logic r, input logic b, input logic [9:0] t,
                       input logic s, input logic rd);
    logic        e_req;
    logic [31:0] e_ins;
    logic [9:0]  e_fpc;
    logic        delivered;
    logic [9:0]  want;
    @(negedge clk);
    rst = r; br = b; tgt = t; stall = s; ready = rd;
    #1;
    if (r) model_reset();
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        e_req = 1'b0; e_ins = 32'h0; e_fpc = rpc(k);
      end else if (b) begin
        e_req = 1'b0; e_ins = 32'h0; e_fpc = m_pc[k];
      end else if (m_held[k]) begin
        e_req = 1'b0; e_ins = m_bi[k]; e_fpc = m_bp[k];
      end else begin
        e_req = 1'b1; e_ins = rd ? mem(m_pc[k]) : 32'h0; e_fpc = m_pc[k];
      end
      chk($sformatf("req[%0d]", k),  (k == 0) ? req_a  : req_b,  e_req);
      chk($sformatf("addr[%0d]", k), (k == 0) ? addr_a : addr_b, m_pc[k]);
      chk($sformatf("ins[%0d]", k),  (k == 0) ? ins_a  : ins_b,  e_ins);
      chk($sformatf("fpc[%0d]", k),  (k == 0) ? fpc_a  : fpc_b,  e_fpc);
      chk($sformatf("held[%0d]", k), (k == 0) ? held_a : held_b, (!r && m_held[k]));
    end
    delivered = !r && !b && !s && (m_held[0] || rd);
    if (sb_on && delivered) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra: observed delivery of %0h expected none", fpc_a);
      end else begin
        want = exp_q.pop_front();
        chk("sb_order", fpc_a, want);
      end
    end
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        if (b) begin
          m_pc[k] = t; m_held[k] = 1'b0;
        end else if (m_held[k]) begin
          if (!s) m_held[k] = 1'b0;
        end else if (rd) begin
          if (s) begin
            m_held[k] = 1'b1; m_bi[k] = mem(m_pc[k]); m_bp[k] = m_pc[k];
          end
          m_pc[k] = m_pc[k] + 10'd1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; br = 1'b0; tgt = 10'd0; stall = 1'b0; ready = 1'b0;
    sb_on = 1'b1;
    model_reset();

    // Reset, then free-run with a three-cycle memory wait on PC 2.
    cycle(1, 0, 10'd0, 0, 1);
    exp_q.push_back(10'd0); exp_q.push_back(10'd1);
    exp_q.push_back(10'd2); exp_q.push_back(10'd3);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 0);
    cycle(0, 0, 10'd0, 1, 0);
    cycle(0, 0, 10'd0, 0, 0);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);

    // Stall skid on the word at PC 5.
    exp_q.push_back(10'd4); exp_q.push_back(10'd5); exp_q.push_back(10'd6);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 1, 1);
    cycle(0, 0, 10'd0, 1, 1);
    cycle(0, 0, 10'd0, 1, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);

    // Branch at PC 7 to 0x120.
    exp_q.push_back(10'h120); exp_q.push_back(10'h121);
    cycle(0, 1, 10'h120, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);

    // Branch while HELD with Stall high: word 0x122 is dropped.
    exp_q.push_back(10'h200); exp_q.push_back(10'h201);
    cycle(0, 0, 10'd0, 1, 1);
    cycle(0, 1, 10'h200, 1, 1);
    cycle(0, 0, 10'd0, 1, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);
    chk("sb_drain", exp_q.size(), 0);
    sb_on = 1'b0;

    // Wrap from 3FE on the second instance, then async reset during a wait.
    cycle(1, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 1);
    cycle(0, 0, 10'd0, 0, 0);
    cycle(1, 0, 10'd0, 0, 0);
    cycle(0, 0, 10'd0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 7) == 0),
            10'($urandom_range(0, 1023)),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
